// File: rtl/monitor_cmd_arbiter.sv
// Two-source round-robin command arbiter with single-outstanding-read response routing.
// Define CMD_ARB_TIMEOUT_EN to abandon reads left unanswered for TIMEOUT_CYCLES cycles.
module monitor_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [39:0] src0_cmd,
  input  logic [39:0] src1_cmd,
  input  logic        src0_cmd_ready,
  input  logic        src1_cmd_ready,
  output logic        src0_cmd_read_en,
  output logic        src1_cmd_read_en,
  output logic [39:0] cmd,
  output logic        cmd_ready,
  input  logic        cmd_read_en,
  input  logic [39:0] read_msg,
  input  logic        read_msg_ready,
  output logic [39:0] rsp0_msg,
  output logic [39:0] rsp1_msg,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] stray_count,
  output logic [15:0] timeout_count
);

  localparam int unsigned CMD_W = 40;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CMD_W-1:0] rsp0_msg_q, rsp0_msg_d;
  logic [CMD_W-1:0] rsp1_msg_q, rsp1_msg_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [CNT_W-1:0] stray_q, stray_d;

  logic             grant;
  logic [CMD_W-1:0] owner_cmd;
  logic             owner_rdy;
  logic             tmo_hit;

  // Combinational pass-through of the owner's command while granted
  assign grant     = (state_q == GRANT);
  assign owner_cmd = owner_q ? src1_cmd : src0_cmd;
  assign owner_rdy = owner_q ? src1_cmd_ready : src0_cmd_ready;

  assign cmd              = grant ? owner_cmd : '0;
  assign cmd_ready        = grant & owner_rdy;
  assign src0_cmd_read_en = grant & ~owner_q & cmd_read_en;
  assign src1_cmd_read_en = grant &  owner_q & cmd_read_en;

  assign rsp0_msg    = rsp0_msg_q;
  assign rsp1_msg    = rsp1_msg_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign stray_count = stray_q;

`ifdef CMD_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;

  assign tmo_hit       = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_count = timeout_q;

  // Wait counter restarts on every grant so it is zero on WAIT_RSP entry
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    if (state_q == GRANT) begin
      tmo_cnt_d = '0;
    end else if (state_q == WAIT_RSP) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
    if ((state_q == WAIT_RSP) && !read_msg_ready && tmo_hit && (timeout_q != '1)) begin
      timeout_d = timeout_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign tmo_hit       = 1'b0;
  assign timeout_count = '0;
`endif

  // Next-state, arbitration and response routing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    rsp0_msg_d   = rsp0_msg_q;
    rsp1_msg_d   = rsp1_msg_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    stray_d      = stray_q;

    if (read_msg_ready && (state_q != WAIT_RSP) && (stray_q != '1)) begin
      stray_d = stray_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        case ({src1_cmd_ready, src0_cmd_ready})
          2'b01: begin
            owner_d = 1'b0;
            state_d = GRANT;
          end
          2'b10: begin
            owner_d = 1'b1;
            state_d = GRANT;
          end
          2'b11: begin
            owner_d = ~last_q;
            state_d = GRANT;
          end
          default: state_d = IDLE;
        endcase
      end
      GRANT: begin
        if (cmd_read_en) begin
          last_d  = owner_q;
          state_d = owner_cmd[CMD_W-1] ? IDLE : WAIT_RSP;
        end else if (!owner_rdy) begin
          state_d = IDLE;
        end
      end
      WAIT_RSP: begin
        if (read_msg_ready) begin
          if (owner_q) begin
            rsp1_msg_d   = read_msg;
            rsp1_valid_d = 1'b1;
          end else begin
            rsp0_msg_d   = read_msg;
            rsp0_valid_d = 1'b1;
          end
          state_d = IDLE;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      rsp0_msg_q   <= '0;
      rsp1_msg_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      stray_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      rsp0_msg_q   <= rsp0_msg_d;
      rsp1_msg_q   <= rsp1_msg_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      stray_q      <= stray_d;
    end
  end

endmodule

// File: tb/tb_monitor_cmd_arbiter.sv
// Scoreboard bench for monitor_cmd_arbiter: directed commands/responses, expectations queued,
// a monitor pops and compares every accepted command and every routed response.
module tb_monitor_cmd_arbiter;

  logic        clk;
  logic        rst_n;
  logic [39:0] src0_cmd, src1_cmd;
  logic        src0_cmd_ready, src1_cmd_ready;
  logic        src0_cmd_read_en, src1_cmd_read_en;
  logic [39:0] cmd;
  logic        cmd_ready;
  logic        cmd_read_en;
  logic [39:0] read_msg;
  logic        read_msg_ready;
  logic [39:0] rsp0_msg, rsp1_msg;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] stray_count, timeout_count;

  typedef struct {
    logic        src;
    logic [39:0] data;
  } exp_t;

  exp_t        exp_cmd_q[$];
  exp_t        exp_rsp_q[$];
  logic [39:0] sq0[$];
  logic [39:0] sq1[$];

  int errors = 0;
  int checks = 0;

  monitor_cmd_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .src0_cmd         (src0_cmd),
    .src1_cmd         (src1_cmd),
    .src0_cmd_ready   (src0_cmd_ready),
    .src1_cmd_ready   (src1_cmd_ready),
    .src0_cmd_read_en (src0_cmd_read_en),
    .src1_cmd_read_en (src1_cmd_read_en),
    .cmd              (cmd),
    .cmd_ready        (cmd_ready),
    .cmd_read_en      (cmd_read_en),
    .read_msg         (read_msg),
    .read_msg_ready   (read_msg_ready),
    .rsp0_msg         (rsp0_msg),
    .rsp1_msg         (rsp1_msg),
    .rsp0_valid       (rsp0_valid),
    .rsp1_valid       (rsp1_valid),
    .stray_count      (stray_count),
    .timeout_count    (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source FIFO models: pop on an observed read strobe, present the head word
  always @(posedge clk) begin
    logic p0, p1;
    p0 = src0_cmd_read_en;
    p1 = src1_cmd_read_en;
    #1;
    if (p0 && sq0.size() > 0) sq0.delete(0);
    if (p1 && sq1.size() > 0) sq1.delete(0);
    src0_cmd_ready = (sq0.size() > 0);
    src1_cmd_ready = (sq1.size() > 0);
    src0_cmd       = (sq0.size() > 0) ? sq0[0] : 40'h0;
    src1_cmd       = (sq1.size() > 0) ? sq1[0] : 40'h0;
  end

  // Controller model: accepts whatever is offered
  always @(negedge clk) begin
    #1;
    cmd_read_en = cmd_ready;
  end

  // Monitor: compare every accept and every response strobe against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (rst_n) begin
      if (cmd_ready && cmd_read_en) begin
        checks++;
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL accept_unexpected: got cmd=%h rd0=%b rd1=%b, none expected",
                   cmd, src0_cmd_read_en, src1_cmd_read_en);
        end else begin
          e = exp_cmd_q.pop_front();
          if (cmd !== e.data || src0_cmd_read_en !== !e.src || src1_cmd_read_en !== e.src) begin
            errors++;
            $display("FAIL accept: got cmd=%h rd0=%b rd1=%b, expected cmd=%h from src%0d",
                     cmd, src0_cmd_read_en, src1_cmd_read_en, e.data, e.src);
          end
        end
      end
      if (rsp0_valid || rsp1_valid) begin
        checks++;
        if (rsp0_valid && rsp1_valid) begin
          errors++;
          $display("FAIL rsp_both: got both rsp valids high, expected at most one");
        end else if (exp_rsp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got v0=%b v1=%b m0=%h m1=%h, none expected",
                   rsp0_valid, rsp1_valid, rsp0_msg, rsp1_msg);
        end else begin
          e = exp_rsp_q.pop_front();
          if (rsp1_valid !== e.src || (rsp1_valid ? rsp1_msg : rsp0_msg) !== e.data) begin
            errors++;
            $display("FAIL rsp: got v1=%b msg=%h, expected src%0d msg=%h",
                     rsp1_valid, rsp1_valid ? rsp1_msg : rsp0_msg, e.src, e.data);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    #2;
  endtask

  task automatic push_cmd(input logic src, input logic [39:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    if (src) sq1.push_back(data);
    else     sq0.push_back(data);
    exp_cmd_q.push_back(e);
  endtask

  task automatic expect_rsp(input logic src, input logic [39:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    exp_rsp_q.push_back(e);
  endtask

  task automatic send_rsp(input logic [39:0] data);
    @(negedge clk);
    #1;
    read_msg       = data;
    read_msg_ready = 1'b1;
    @(negedge clk);
    #1;
    read_msg_ready = 1'b0;
  endtask

  // Bounded wait for the monitor to drain every expectation
  task automatic wait_drain(input string nm, input int bound);
    int n;
    n = 0;
    while ((exp_cmd_q.size() > 0 || exp_rsp_q.size() > 0) && n < bound) begin
      @(negedge clk);
      #4;
      n++;
    end
    checks++;
    if (exp_cmd_q.size() > 0 || exp_rsp_q.size() > 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d cmds %0d rsps pending, expected 0",
               nm, exp_cmd_q.size(), exp_rsp_q.size());
      exp_cmd_q.delete();
      exp_rsp_q.delete();
    end
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    src0_cmd       = '0;
    src1_cmd       = '0;
    src0_cmd_ready = 1'b0;
    src1_cmd_ready = 1'b0;
    cmd_read_en    = 1'b0;
    read_msg       = '0;
    read_msg_ready = 1'b0;

    // Reset state
    #3;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_cmd", 64'(cmd), 64'd0);
    check("rst_read_en", 64'({src0_cmd_read_en, src1_cmd_read_en}), 64'd0);
    check("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    check("rst_rsp_msgs", 64'(rsp0_msg | rsp1_msg), 64'd0);
    check("rst_counts", 64'({stray_count, timeout_count}), 64'd0);
    repeat (2) at_neg();
    rst_n = 1'b1;
    at_neg();

    // Round robin: both sources hold two writes, src0 first after reset
    push_cmd(1'b0, 40'h80_0000_0001);
    push_cmd(1'b1, 40'h80_1000_0001);
    push_cmd(1'b0, 40'h80_0000_0002);
    push_cmd(1'b1, 40'h80_1000_0002);
    wait_drain("rr_writes", 60);

    // src0 read with a response three cycles after the accept
    push_cmd(1'b0, 40'h01_0010_0000);
    wait_drain("src0_read", 20);
    repeat (3) at_neg();
    expect_rsp(1'b0, 40'h81_0010_1234);
    send_rsp(40'h81_0010_1234);
    wait_drain("src0_rsp", 10);
    repeat (3) at_neg();
    check("rsp0_msg_hold", 64'(rsp0_msg), 64'h81_0010_1234);
    check("rsp1_msg_untouched", 64'(rsp1_msg), 64'd0);

    // src1 read outstanding blocks src0 until the response routes
    push_cmd(1'b1, 40'h02_0020_0000);
    wait_drain("src1_read", 20);
    push_cmd(1'b0, 40'h80_0000_0033);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("wait_rsp_no_cmd", 64'(cmd_ready), 64'd0);
    end
    expect_rsp(1'b1, 40'h82_0020_5678);
    send_rsp(40'h82_0020_5678);
    #1;
    check("cmd_ready_rsp_cycle", 64'(cmd_ready), 64'd0);
    at_neg();
    check("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
    wait_drain("src0_after_rsp", 10);

    // Response strobe coinciding with a grant accept is stray
    push_cmd(1'b0, 40'h80_0000_0044);
    n = 0;
    do begin
      at_neg();
      n++;
    end while (!cmd_ready && n < 20);
    check("grant_seen", 64'(cmd_ready), 64'd1);
    read_msg       = 40'h8F_0000_0001;
    read_msg_ready = 1'b1;
    @(negedge clk);
    #1;
    read_msg_ready = 1'b0;
    #1;
    check("stray_on_accept", 64'(stray_count), 64'd1);
    wait_drain("stray_accept", 10);

    // Response strobe while idle is stray
    at_neg();
    send_rsp(40'h8F_0000_0002);
    #1;
    check("stray_idle", 64'(stray_count), 64'd2);
    check("stray_idle_no_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);

    // Read with no response
    push_cmd(1'b1, 40'h03_0030_0000);
    wait_drain("tmo_read", 20);
`ifdef CMD_ARB_TIMEOUT_EN
    repeat (18) at_neg();
    check("timeout_count", 64'(timeout_count), 64'd1);
    push_cmd(1'b0, 40'h80_0000_0055);
    wait_drain("after_timeout", 10);
`else
    repeat (10000) at_neg();
    check("no_timeout_count", 64'(timeout_count), 64'd0);
    check("still_waiting", 64'(cmd_ready), 64'd0);
    expect_rsp(1'b1, 40'h83_0030_9ABC);
    send_rsp(40'h83_0030_9ABC);
    wait_drain("late_rsp", 10);
`endif

    // Reset during WAIT_RSP discards the read
    push_cmd(1'b1, 40'h04_0040_0000);
    wait_drain("rst_read", 20);
    repeat (2) at_neg();
    rst_n = 1'b0;
    at_neg();
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("midrst_counts", 64'({stray_count, timeout_count}), 64'd0);
    check("midrst_rsp_msgs", 64'(rsp0_msg | rsp1_msg), 64'd0);
    at_neg();
    rst_n = 1'b1;
    send_rsp(40'h84_0040_0000);
    #1;
    check("stray_after_rst", 64'(stray_count), 64'd1);
    at_neg();
    push_cmd(1'b0, 40'h80_0000_0077);
    push_cmd(1'b1, 40'h80_1000_0077);
    wait_drain("grant_after_rst", 20);

    // Stray counter saturation
    at_neg();
    read_msg_ready = 1'b1;
    repeat (65533) @(negedge clk);
    #2;
    check("stray_near_sat", 64'(stray_count), 64'hFFFE);
    repeat (3) @(negedge clk);
    read_msg_ready = 1'b0;
    #2;
    check("stray_saturated", 64'(stray_count), 64'hFFFF);
    repeat (3) at_neg();
    check("stray_hold", 64'(stray_count), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/monitor_cmd_arbiter.md
MONITOR_CMD_ARBITER -- requirements
Module: monitor_cmd_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 4096, cycles a read may stay outstanding before it is abandoned (only used when CMD_ARB_TIMEOUT_EN is defined).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have ports: src0_cmd / src1_cmd  input  40  command words from host USB FIFO (0) and auxiliary bridge FIFO (1).
REQ-005 SHALL have ports: src0_cmd_ready / src1_cmd_ready  input  1  source FIFO non-empty.
REQ-006 SHALL have ports: src0_cmd_read_en / src1_cmd_read_en  output  1  pop strobe to the source FIFO.
REQ-007 SHALL have port: cmd  output  40  command presented to the command controller.
REQ-008 SHALL have port: cmd_ready  output  1  command valid toward the controller.
REQ-009 SHALL have port: cmd_read_en  input  1  controller accept strobe.
REQ-010 SHALL have ports: read_msg  input  40 and read_msg_ready  input  1; controller read response.
REQ-011 SHALL have ports: rsp0_msg / rsp1_msg  output  40  routed response word per source.
REQ-012 SHALL have ports: rsp0_valid / rsp1_valid  output  1  one-cycle response strobe per source.
REQ-013 SHALL have port: stray_count  output  16  saturating count of unexpected responses.
REQ-014 SHALL have port: timeout_count  output  16  saturating count of abandoned reads.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT and WAIT_RSP, plus a 1-bit owner register and a 1-bit round-robin pointer (last_served).
REQ-016 In IDLE with exactly one srcN_cmd_ready high, SHALL set owner=N and enter GRANT next cycle.
REQ-017 In IDLE with both ready, SHALL grant the source other than last_served; after reset, last_served=1, so src0 wins first.
REQ-018 In GRANT, cmd/cmd_ready SHALL combinationally equal the owner's src cmd/ready; outside GRANT, cmd=0 and cmd_ready=0.
REQ-019 In GRANT, the owner's srcN_cmd_read_en SHALL equal cmd_read_en in the same cycle; the non-owner read_en SHALL be 0 in all states.
REQ-020 On accept in GRANT, last_served SHALL be set to owner; if cmd[39]=1 (write), go to IDLE, else go to WAIT_RSP.
REQ-021 In GRANT with the owner's ready low and no accept, SHALL return to IDLE without updating last_served.
REQ-022 In WAIT_RSP on read_msg_ready, SHALL register read_msg into rspN_msg of owner, pulse rspN_valid the next cycle for exactly one cycle, and enter IDLE.
REQ-023 Response latency SHALL be exactly 1 cycle from read_msg_ready to rspN_valid; rspN_msg SHALL hold its value until the next routed response.
REQ-024 At most one read SHALL be outstanding; no command SHALL be presented while in WAIT_RSP.
REQ-025 A read_msg_ready outside WAIT_RSP SHALL be dropped: no rsp strobe, stray_count+1, saturating at 16'hFFFF.
REQ-026 A read_msg_ready in the same cycle as a GRANT accept SHALL be counted as stray.

Reset
REQ-027 On rst_n low, SHALL asynchronously force state=IDLE, owner=0, last_served=1, rsp0_msg=rsp1_msg=0, rsp valids=0, stray_count=0 and timeout_count=0; combinational outputs SHALL then read cmd=0, cmd_ready=0 and read_en=0.
REQ-028 A reset during WAIT_RSP SHALL discard the outstanding read; a response arriving after reset release SHALL be counted as stray.

Configuration
REQ-029 With CMD_ARB_TIMEOUT_EN defined: a cycle counter SHALL clear on WAIT_RSP entry; if TIMEOUT_CYCLES elapse without read_msg_ready, the FSM SHALL go to IDLE, timeout_count+1 (saturating), with no rsp strobe.
REQ-030 Without CMD_ARB_TIMEOUT_EN, WAIT_RSP SHALL wait indefinitely, timeout_count SHALL be constant 0, and no timeout counter SHALL be synthesised.

Verification
REQ-031 src0 read 40'h01_0010_0000; response 40'h81_0010_1234 three cycles later -> src0_cmd_read_en one pulse, rsp0_valid one pulse with rsp0_msg=40'h81_0010_1234, rsp1_valid never asserted.
REQ-032 Both sources hold two write commands each, always ready -> accept order src0, src1, src0, src1.
REQ-033 src1 read accepted, then src0 ready during WAIT_RSP -> cmd_ready stays 0 until the cycle after the src1 response routes, then src0 is granted.
REQ-034 read_msg_ready pulsed while IDLE -> no rsp strobe and stray_count=1; 65536 further pulses -> stray_count=16'hFFFF.
REQ-035 Macro defined, TIMEOUT_CYCLES=16, read with no response -> IDLE after 16 cycles and timeout_count=1; macro undefined -> still in WAIT_RSP after 10000 cycles.
REQ-036 rst_n pulsed low in WAIT_RSP, then a response arrives -> no rsp strobe, stray_count=1, and the next grant goes to src0.
